// File: rtl/block_mem_pkg.sv
// block_mem_pkg: shared FSM states, port IDs and block sizing for block_mem_arbiter.
package block_mem_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_PARK  = 2'd1;
    localparam arb_state_t ST_ISSUE = 2'd2;
    localparam arb_state_t ST_RESP  = 2'd3;

    localparam logic PORT_D = 1'b0;
    localparam logic PORT_I = 1'b1;

    function automatic int block_size(input int offset_width);
        return 1 << offset_width;
    endfunction

endpackage

// File: rtl/block_arb_pick.sv
// block_arb_pick: two-way grant; prio selects which port wins a tie.
module block_arb_pick (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic       gnt_any,
    output logic       gnt_id
);

    assign gnt_any = |valid;
    // port 1 wins when alone, or when both are valid and it holds priority
    assign gnt_id  = valid[1] & (~valid[0] | prio);

endmodule

// File: rtl/block_mem_arbiter.sv
// block_mem_arbiter: serialises two block requesters onto the delayed memory.
// Define BLK_ARB_RR_EN for round-robin grant; fixed priority (port 0) otherwise.
module block_mem_arbiter
    import block_mem_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 10,
    parameter int BLOCK_OFFSET_WIDTH = 3
) (
    input  logic                                                 clk,
    input  logic                                                 rstn,
    input  logic                                                 req0_valid,
    output logic                                                 req0_ready,
    input  logic                                                 req0_we,
    input  logic [ADDR_WIDTH-1:0]                                req0_addr,
    input  logic [block_size(BLOCK_OFFSET_WIDTH)*DATA_WIDTH-1:0] req0_wdata,
    input  logic                                                 req1_valid,
    output logic                                                 req1_ready,
    input  logic                                                 req1_we,
    input  logic [ADDR_WIDTH-1:0]                                req1_addr,
    input  logic [block_size(BLOCK_OFFSET_WIDTH)*DATA_WIDTH-1:0] req1_wdata,
    output logic                                                 resp0_valid,
    output logic                                                 resp1_valid,
    output logic [block_size(BLOCK_OFFSET_WIDTH)*DATA_WIDTH-1:0] resp_rdata,
    output logic [ADDR_WIDTH-1:0]                                mem_addr,
    output logic                                                 mem_we,
    output logic [block_size(BLOCK_OFFSET_WIDTH)*DATA_WIDTH-1:0] mem_block_din,
    input  logic                                                 mem_block_valid,
    input  logic [block_size(BLOCK_OFFSET_WIDTH)*DATA_WIDTH-1:0] mem_block_dout
);

    localparam int BS = block_size(BLOCK_OFFSET_WIDTH);
    localparam int BW = BS * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'(BS - 1);
    localparam logic [ADDR_WIDTH-1:0] BS_A     = ADDR_WIDTH'(BS);

    arb_state_t            state_q, state_d;
    logic                  gnt_q, gnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  first_q, first_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_we_q, mem_we_d;
    logic [BW-1:0]         mem_din_q, mem_din_d;
    logic                  resp0_q, resp0_d;
    logic                  resp1_q, resp1_d;
    logic [BW-1:0]         rdata_q, rdata_d;

    logic                  pick_any;
    logic                  pick_id;
    logic                  pick_prio;
    logic [ADDR_WIDTH-1:0] sel_aligned;

`ifdef BLK_ARB_RR_EN
    logic prio_q, prio_d;

    always_comb begin
        prio_d = prio_q;
        if (state_q == ST_IDLE && pick_any) prio_d = ~pick_id;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) prio_q <= 1'b0;
        else       prio_q <= prio_d;
    end

    assign pick_prio = prio_q;
`else
    assign pick_prio = 1'b0;
`endif

    block_arb_pick u_pick (
        .valid   ({req1_valid, req0_valid}),
        .prio    (pick_prio),
        .gnt_any (pick_any),
        .gnt_id  (pick_id)
    );

    assign sel_aligned = (pick_id ? req1_addr : req0_addr) & ~OFS_MASK;

    assign req0_ready = (state_q == ST_IDLE) && pick_any && (pick_id == PORT_D);
    assign req1_ready = (state_q == ST_IDLE) && pick_any && (pick_id == PORT_I);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        first_d    = first_q;
        mem_addr_d = mem_addr_q;
        mem_we_d   = 1'b0;
        mem_din_d  = mem_din_q;
        resp0_d    = 1'b0;
        resp1_d    = 1'b0;
        rdata_d    = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d    = ST_PARK;
                    gnt_d      = pick_id;
                    we_d       = pick_id ? req1_we : req0_we;
                    addr_d     = sel_aligned;
                    mem_din_d  = pick_id ? req1_wdata : req0_wdata;
                    // a neighbouring block forces an address change
                    mem_addr_d = sel_aligned ^ BS_A;
                end
            end
            ST_PARK: begin
                state_d    = ST_ISSUE;
                mem_addr_d = addr_q;
                mem_we_d   = we_q;
                first_d    = 1'b1;
            end
            ST_ISSUE: begin
                mem_we_d = we_q;
                first_d  = 1'b0;
                if (!first_q && mem_block_valid) begin
                    state_d  = ST_RESP;
                    mem_we_d = 1'b0;
                    resp0_d  = (gnt_q == PORT_D);
                    resp1_d  = (gnt_q == PORT_I);
                    if (!we_q) rdata_d = mem_block_dout;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            gnt_q      <= PORT_D;
            we_q       <= 1'b0;
            addr_q     <= '0;
            first_q    <= 1'b0;
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            mem_din_q  <= '0;
            resp0_q    <= 1'b0;
            resp1_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            first_q    <= first_d;
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= mem_we_d;
            mem_din_q  <= mem_din_d;
            resp0_q    <= resp0_d;
            resp1_q    <= resp1_d;
            rdata_q    <= rdata_d;
        end
    end

    assign mem_addr      = mem_addr_q;
    assign mem_we        = mem_we_q;
    assign mem_block_din = mem_din_q;
    assign resp0_valid   = resp0_q;
    assign resp1_valid   = resp1_q;
    assign resp_rdata    = rdata_q;

endmodule

// File: tb/tb_block_mem_arbiter.sv
// tb_block_mem_arbiter: directed bench with a small delayed block memory.
// Build with +define+BLK_ARB_RR_EN to check round-robin expectations.
module tb_block_mem_arbiter;

    logic         clk;
    logic         rstn;
    logic         req0_valid, req0_ready, req0_we;
    logic [9:0]   req0_addr;
    logic [255:0] req0_wdata;
    logic         req1_valid, req1_ready, req1_we;
    logic [9:0]   req1_addr;
    logic [255:0] req1_wdata;
    logic         resp0_valid, resp1_valid;
    logic [255:0] resp_rdata;
    logic [9:0]   mem_addr;
    logic         mem_we;
    logic [255:0] mem_block_din;
    logic         mem_block_valid;
    logic [255:0] mem_block_dout;

    int tests = 0;
    int fails = 0;

    block_mem_arbiter #(
        .DATA_WIDTH         (32),
        .ADDR_WIDTH         (10),
        .BLOCK_OFFSET_WIDTH (3)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .req0_valid      (req0_valid),
        .req0_ready      (req0_ready),
        .req0_we         (req0_we),
        .req0_addr       (req0_addr),
        .req0_wdata      (req0_wdata),
        .req1_valid      (req1_valid),
        .req1_ready      (req1_ready),
        .req1_we         (req1_we),
        .req1_addr       (req1_addr),
        .req1_wdata      (req1_wdata),
        .resp0_valid     (resp0_valid),
        .resp1_valid     (resp1_valid),
        .resp_rdata      (resp_rdata),
        .mem_addr        (mem_addr),
        .mem_we          (mem_we),
        .mem_block_din   (mem_block_din),
        .mem_block_valid (mem_block_valid),
        .mem_block_dout  (mem_block_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // delayed memory: an address change restarts a 3-cycle access
    logic [31:0] mem [0:1023];
    logic [9:0]  prev_addr;
    logic [2:0]  cnt;

    initial for (int i = 0; i < 1024; i++) mem[i] = 32'(i);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_addr <= '0;
            cnt       <= '0;
        end else begin
            prev_addr <= mem_addr;
            if (mem_addr != prev_addr) cnt <= 3'd3;
            else if (cnt != 3'd0)      cnt <= cnt - 3'd1;
        end
    end

    always @(posedge clk)
        if (rstn && mem_block_valid && mem_we)
            for (int i = 0; i < 8; i++)
                mem[{mem_addr[9:3], 3'(i)}] <= mem_block_din[i*32 +: 32];

    assign mem_block_valid = (mem_addr == prev_addr) && (cnt == 3'd1);

    always_comb begin
        mem_block_dout = '0;
        for (int i = 0; i < 8; i++)
            mem_block_dout[i*32 +: 32] = mem[{mem_addr[9:3], 3'(i)}];
    end

    function automatic logic [255:0] seq_blk(input logic [31:0] base);
        logic [255:0] b;
        for (int i = 0; i < 8; i++) b[i*32 +: 32] = base + 32'(i);
        return b;
    endfunction

    function automatic logic rdy(input int p);
        return (p == 0) ? req0_ready : req1_ready;
    endfunction

    function automatic logic rsp(input int p);
        return (p == 0) ? resp0_valid : resp1_valid;
    endfunction

    task automatic set_req(input int p, input logic v, input logic we,
                           input logic [9:0] a, input logic [255:0] d);
        if (p == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        set_req(0, 1'b0, 1'b0, 10'h0, '0);
        set_req(1, 1'b0, 1'b0, 10'h0, '0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    // one full transaction with park/issue/response checks
    task automatic do_txn(input int p, input logic we, input logic [9:0] a,
                          input logic [255:0] d, input logic [255:0] exp_rd);
        int n;
        logic [9:0] al;
        al = {a[9:3], 3'b000};
        @(negedge clk);
        set_req(p, 1'b1, we, a, d);
        n = 0;
        while (!rdy(p) && n < 40) begin @(negedge clk); n++; end
        tests++;
        if (!rdy(p)) begin
            fails++;
            $display("FAIL txn_ready p%0d: ready=%b required 1", p, rdy(p));
        end
        @(negedge clk);
        set_req(p, 1'b0, we, a, d);
        tests++;
        if (mem_addr !== (al ^ 10'h008) || mem_we !== 1'b0) begin
            fails++;
            $display("FAIL txn_park p%0d: addr=%h we=%b required %h 0",
                     p, mem_addr, mem_we, al ^ 10'h008);
        end
        @(negedge clk);
        tests++;
        if (mem_addr !== al || mem_we !== we || (we && mem_block_din !== d)) begin
            fails++;
            $display("FAIL txn_issue p%0d: addr=%h we=%b required %h %b",
                     p, mem_addr, mem_we, al, we);
        end
        n = 0;
        while (!mem_block_valid && n < 40) begin @(negedge clk); n++; end
        @(negedge clk);
        tests++;
        if (rsp(p) !== 1'b1 || rsp(1 - p) !== 1'b0 || mem_we !== 1'b0) begin
            fails++;
            $display("FAIL txn_resp p%0d: r0=%b r1=%b we=%b", p,
                     resp0_valid, resp1_valid, mem_we);
        end
        if (!we) begin
            tests++;
            if (resp_rdata !== exp_rd) begin
                fails++;
                $display("FAIL txn_rdata p%0d: got %h required %h", p,
                         resp_rdata, exp_rd);
            end
        end
        @(negedge clk);
        tests++;
        if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin
            fails++;
            $display("FAIL txn_resp_pulse p%0d: r0=%b r1=%b required 0 0",
                     p, resp0_valid, resp1_valid);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        set_req(0, 1'b0, 1'b0, 10'h0, '0);
        set_req(1, 1'b0, 1'b0, 10'h0, '0);
        repeat (3) @(negedge clk);
        tests++;
        if (mem_addr !== 10'h0 || mem_we !== 1'b0 || mem_block_din !== '0) begin
            fails++;
            $display("FAIL reset_mem: addr=%h we=%b", mem_addr, mem_we);
        end
        tests++;
        if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0 || resp_rdata !== '0) begin
            fails++;
            $display("FAIL reset_resp: r0=%b r1=%b", resp0_valid, resp1_valid);
        end
        rstn = 1'b1;
        @(negedge clk);
        tests++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: rdy0=%b rdy1=%b required 0 0",
                     req0_ready, req1_ready);
        end
    endtask

    task automatic test_read_p0();
        do_txn(0, 1'b0, 10'h013, '0, seq_blk(32'h10));
    endtask

    task automatic test_write_read_p1();
        do_txn(1, 1'b1, 10'h020, seq_blk(32'h1), '0);
        do_txn(1, 1'b0, 10'h020, '0, seq_blk(32'h1));
    endtask

    task automatic test_priority();
        int n;
        int got;
        int exp_p;
        do_reset();
        set_req(0, 1'b1, 1'b0, 10'h040, '0);
        set_req(1, 1'b1, 1'b0, 10'h080, '0);
        for (int k = 0; k < 5; k++) begin
            if (k == 4) set_req(0, 1'b0, 1'b0, 10'h040, '0);
`ifdef BLK_ARB_RR_EN
            exp_p = k % 2;
`else
            exp_p = (k == 4) ? 1 : 0;
`endif
            if (k == 4) exp_p = 1;
            n = 0;
            while (!(req0_ready || req1_ready) && n < 40) begin
                @(negedge clk); n++;
            end
            got = req1_ready ? 1 : 0;
            tests++;
            if ((req0_ready ^ req1_ready) !== 1'b1 || got != exp_p) begin
                fails++;
                $display("FAIL prio_grant%0d: rdy0=%b rdy1=%b required port %0d",
                         k, req0_ready, req1_ready, exp_p);
            end
            @(negedge clk);
        end
        set_req(1, 1'b0, 1'b0, 10'h080, '0);
        n = 0;
        while (!resp1_valid && n < 40) begin @(negedge clk); n++; end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_issue();
        int n;
        logic [255:0] d;
        d = seq_blk(32'hA000);
        do_reset();
        set_req(0, 1'b1, 1'b1, 10'h100, d);
        n = 0;
        while (!req0_ready && n < 40) begin @(negedge clk); n++; end
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (mem_we !== 1'b1) begin
            fails++;
            $display("FAIL rst_issue_we: we=%b required 1", mem_we);
        end
        rstn = 1'b0;
        #1;
        tests++;
        if (mem_we !== 1'b0 || mem_addr !== 10'h0) begin
            fails++;
            $display("FAIL rst_issue_clear: we=%b addr=%h required 0 000",
                     mem_we, mem_addr);
        end
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp0_valid !== 1'b0) n++;
        end
        tests++;
        if (n != 0) begin
            fails++;
            $display("FAIL rst_issue_noresp: resp0 high %0d cycles required 0", n);
        end
        rstn = 1'b1;
        do_txn(0, 1'b1, 10'h100, d, '0);
        do_txn(0, 1'b0, 10'h100, '0, d);
    endtask

    task automatic test_late_req1();
        int n;
        int bad;
        do_reset();
        set_req(0, 1'b1, 1'b0, 10'h013, '0);
        n = 0;
        while (!req0_ready && n < 40) begin @(negedge clk); n++; end
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 10'h013, '0);
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 10'h020, '0);
        bad = 0;
        n = 0;
        while (!resp0_valid && n < 40) begin
            if (req1_ready !== 1'b0) bad++;
            @(negedge clk); n++;
        end
        tests++;
        if (resp0_valid !== 1'b1 || req1_ready !== 1'b0 || bad != 0) begin
            fails++;
            $display("FAIL late_hold: resp0=%b rdy1=%b early=%0d required 1 0 0",
                     resp0_valid, req1_ready, bad);
        end
        @(negedge clk);
        tests++;
        if (req1_ready !== 1'b1 || resp0_valid !== 1'b0) begin
            fails++;
            $display("FAIL late_accept: rdy1=%b resp0=%b required 1 0",
                     req1_ready, resp0_valid);
        end
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, 10'h020, '0);
        n = 0;
        while (!resp1_valid && n < 40) begin @(negedge clk); n++; end
        tests++;
        if (resp1_valid !== 1'b1) begin
            fails++;
            $display("FAIL late_resp1: resp1=%b required 1", resp1_valid);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_read_p0();
        test_write_read_p1();
        test_priority();
        test_reset_mid_issue();
        test_late_req1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
